ascon_permutation: RTL and testbench

Iterative Ascon permutation engine. It accepts a 320-bit state through a valid/ready handshake and applies the requested number of rounds, one round per clock. Each round is constant addition, then substitution, then diffusion, in that order. The diffusion stage's output is registered here and fed back as the next round's input. The block sits between the mode controller (init/AD/data/finalize sequencing) and the round datapath, and returns the permuted state through a valid/ready handshake.

---
 rtl/ascon_pkg.sv | 30 +++
 rtl/ascon_round.sv | 49 ++++
 rtl/ascon_permutation.sv | 108 ++++++++++
 tb/tb_ascon_permutation.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types and helpers for the Ascon permutation engine.
package ascon_pkg;

    // Five 64-bit lanes; element 0 is x0, so {x0, x1, x2, x3, x4} packs naturally.
    typedef logic [0:4][63:0] t_state_array;

    // Depth of the round-constant table; a full permutation uses every entry.
    localparam int MAX_ROUNDS = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } t_perm_fsm;

    // Round constant for index i: high nibble counts down from 15, low nibble up from 0.
    // Indices past the table return zero so a stray index cannot corrupt the state.
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        if (idx < 4'(MAX_ROUNDS)) begin
            return {4'd15 - idx, idx};
        end
        return 8'h00;
    endfunction

    // Rotate a lane right by a fixed amount.
    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bit-sliced S-box, linear diffusion.
module ascon_round
    import ascon_pkg::*;
(
    input  t_state_array i_state,
    input  logic [3:0]   i_round_idx,
    output t_state_array o_state
);

    t_state_array added;
    t_state_array substituted;
    logic [63:0]  a0, a1, a2, a3, a4;
    logic [63:0]  b0, b1, b2, b3, b4;

    // Constant addition touches only the low byte of x2.
    always_comb begin
        added = i_state;
        added[2][7:0] = i_state[2][7:0] ^ round_const(i_round_idx);
    end

    // 5-bit S-box evaluated on all 64 columns at once using its boolean form.
    always_comb begin
        a0 = added[0] ^ added[4];
        a1 = added[1];
        a2 = added[2] ^ added[1];
        a3 = added[3];
        a4 = added[4] ^ added[3];
        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);
        substituted[0] = b0 ^ b4;
        substituted[1] = b1 ^ b0;
        substituted[2] = ~b2;
        substituted[3] = b3 ^ b2;
        substituted[4] = b4;
    end

    // Per-lane diffusion with the lane-specific rotation pairs.
    always_comb begin
        o_state[0] = substituted[0] ^ rotr64(substituted[0], 19) ^ rotr64(substituted[0], 28);
        o_state[1] = substituted[1] ^ rotr64(substituted[1], 61) ^ rotr64(substituted[1], 39);
        o_state[2] = substituted[2] ^ rotr64(substituted[2], 1)  ^ rotr64(substituted[2], 6);
        o_state[3] = substituted[3] ^ rotr64(substituted[3], 10) ^ rotr64(substituted[3], 17);
        o_state[4] = substituted[4] ^ rotr64(substituted[4], 7)  ^ rotr64(substituted[4], 41);
    end

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon permutation: one round per clock, valid/ready on both sides.
// Shorter permutations start part-way into the constant table so they always end on index 11.
module ascon_permutation
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS     = 12,
    parameter int DEFAULT_ROUNDS = 12
) (
    input  logic         i_sys_clk,
    input  logic         i_sys_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  t_state_array i_state,
    input  logic [3:0]   i_rounds,
    input  logic         i_rounds_ovr,
    output logic         o_valid,
    input  logic         i_ready,
    output t_state_array o_state,
    output logic         o_busy
);

    localparam logic [3:0] MAX_R   = 4'(MAX_ROUNDS);
    localparam logic [3:0] DEFAULT_R = 4'(DEFAULT_ROUNDS);

    t_perm_fsm    fsm_q;
    t_perm_fsm    fsm_d;
    t_state_array state_q;
    t_state_array round_out;
    logic [3:0]   idx_q;
    logic [3:0]   remaining_q;
    logic [3:0]   rounds_eff;
    logic         accept;

    ascon_round u_round (
        .i_state     (state_q),
        .i_round_idx (idx_q),
        .o_state     (round_out)
    );

    // Resolve the requested round count: zero means default or pass-through, large values saturate.
    always_comb begin
        rounds_eff = i_rounds;
        if (i_rounds == 4'd0) begin
            rounds_eff = i_rounds_ovr ? 4'd0 : DEFAULT_R;
        end else if (i_rounds > MAX_R) begin
            rounds_eff = MAX_R;
        end
    end

    assign accept  = i_valid & o_ready;
    assign o_state = state_q;

    // FSM state register.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state and handshake outputs; requests are only taken in IDLE.
    always_comb begin
        fsm_d   = fsm_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        case (fsm_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    fsm_d = (rounds_eff == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (remaining_q <= 4'd1) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State register, round index and remaining count: load on accept, advance one round per RUN cycle.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q     <= '0;
            idx_q       <= 4'd0;
            remaining_q <= 4'd0;
        end else if (accept) begin
            state_q     <= i_state;
            idx_q       <= MAX_R - rounds_eff;
            remaining_q <= rounds_eff;
        end else if (fsm_q == RUN) begin
            state_q     <= round_out;
            idx_q       <= idx_q + 4'd1;
            remaining_q <= remaining_q - 4'd1;
        end
    end

endmodule

// File: tb/tb_ascon_permutation.sv
// Scoreboard bench for ascon_permutation: the driver pushes golden results, a monitor pops and compares.
module tb_ascon_permutation;
    import ascon_pkg::*;

    logic         i_sys_clk = 1'b0;
    logic         i_sys_rst_n;
    logic         i_valid;
    logic         o_ready;
    t_state_array i_state;
    logic [3:0]   i_rounds;
    logic         i_rounds_ovr;
    logic         o_valid;
    logic         i_ready;
    t_state_array o_state;
    logic         o_busy;

    typedef struct {
        t_state_array state;
        int           lat;
        longint       accept_edge;
    } t_exp;

    t_exp         exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    longint       edge_count = 0;
    bit           rand_ready = 1'b0;
    bit           ready_force = 1'b1;
    bit           seen = 1'b0;
    t_state_array held;

    localparam logic [7:0] RC_TAB [0:11] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    ascon_permutation dut (
        .i_sys_clk    (i_sys_clk),
        .i_sys_rst_n  (i_sys_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_state      (i_state),
        .i_rounds     (i_rounds),
        .i_rounds_ovr (i_rounds_ovr),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_state      (o_state),
        .o_busy       (o_busy)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    always @(posedge i_sys_clk) edge_count++;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic t_state_array gold_round(input t_state_array s_in, input int idx);
        t_state_array s;
        t_state_array t;
        logic [4:0]   v;
        logic [4:0]   o;
        s = s_in;
        s[2][7:0] = s[2][7:0] ^ RC_TAB[idx];
        for (int c = 0; c < 64; c++) begin
            v = {s[0][c], s[1][c], s[2][c], s[3][c], s[4][c]};
            o = SBOX[v];
            for (int l = 0; l < 5; l++) t[l][c] = o[4 - l];
        end
        s[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
        s[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
        s[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
        s[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
        s[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
        return s;
    endfunction

    function automatic t_state_array gold_perm(input t_state_array s_in, input int r);
        t_state_array s;
        s = s_in;
        for (int i = 12 - r; i < 12; i++) s = gold_round(s, i);
        return s;
    endfunction

    function automatic int model_rounds(input int r, input bit ovr);
        if (r == 0) return ovr ? 0 : 12;
        return (r > 12) ? 12 : r;
    endfunction

    task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: wait expired, got timeout required event", name);
    endtask

    task automatic applyStimulus(input t_state_array st, input logic [3:0] rounds, input bit ovr);
        int   budget;
        int   r;
        t_exp e;
        @(negedge i_sys_clk);
        i_state      = st;
        i_rounds     = rounds;
        i_rounds_ovr = ovr;
        i_valid      = 1'b1;
        budget       = 300;
        while (!o_ready && budget > 0) begin
            @(negedge i_sys_clk);
            budget--;
        end
        if (!o_ready) begin
            timeoutFail("accept_wait");
            i_valid = 1'b0;
            return;
        end
        r             = model_rounds(int'(rounds), ovr);
        e.state       = gold_perm(st, r);
        e.lat         = r + 1;
        e.accept_edge = edge_count + 1;
        exp_q.push_back(e);
        @(negedge i_sys_clk);
        i_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int budget;
        budget = 2000;
        while (!(exp_q.size() == 0 && o_ready) && budget > 0) begin
            @(negedge i_sys_clk);
            budget--;
        end
        if (!(exp_q.size() == 0 && o_ready)) timeoutFail("idle_wait");
    endtask

    // Downstream ready: forced level or random stalls, changed just after each rising edge.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge i_sys_clk);
            #1;
            i_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: pops the scoreboard on the first valid cycle of each result, then checks stability.
    initial begin
        t_exp e;
        forever begin
            @(negedge i_sys_clk);
            if (!i_sys_rst_n) begin
                seen = 1'b0;
            end else begin
                checkOutput("busy_ready_excl", 320'(o_busy & o_ready), 320'(0));
                if (o_valid) begin
                    if (!seen) begin
                        if (exp_q.size() == 0) begin
                            timeoutFail("unexpected_output");
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput("state", o_state, e.state);
                            checkOutput("latency", 320'(edge_count - e.accept_edge + 1), 320'(e.lat));
                        end
                        seen = 1'b1;
                        held = o_state;
                    end else begin
                        checkOutput("stable", o_state, held);
                    end
                    if (i_ready) seen = 1'b0;
                end
            end
        end
    end

    // Main directed sequence.
    initial begin
        t_state_array init_st;
        t_state_array rnd_st;
        logic [3:0]   r4;
        int           budget;

        i_sys_rst_n  = 1'b0;
        i_valid      = 1'b0;
        i_state      = '0;
        i_rounds     = 4'd0;
        i_rounds_ovr = 1'b0;
        #1;
        checkOutput("reset_ready", 320'(o_ready), 320'(1));
        checkOutput("reset_valid", 320'(o_valid), 320'(0));
        checkOutput("reset_busy",  320'(o_busy),  320'(0));
        checkOutput("reset_state", o_state, 320'(0));
        repeat (2) @(negedge i_sys_clk);
        i_sys_rst_n = 1'b1;

        init_st = {64'h80400C0600000000, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
                   64'h0001020304050607, 64'h08090A0B0C0D0E0F};

        $display("[TB] directed round counts");
        applyStimulus(init_st, 4'd12, 1'b0);
        applyStimulus(init_st, 4'd6,  1'b0);
        applyStimulus(init_st, 4'd8,  1'b0);
        applyStimulus(init_st, 4'd15, 1'b0);
        applyStimulus(init_st, 4'd0,  1'b0);
        applyStimulus(init_st, 4'd0,  1'b1);
        applyStimulus(init_st, 4'd1,  1'b0);
        waitIdle();

        $display("[TB] backpressure");
        ready_force = 1'b0;
        repeat (2) @(posedge i_sys_clk);
        applyStimulus(init_st, 4'd8, 1'b0);
        budget = 50;
        while (!o_valid && budget > 0) begin
            @(negedge i_sys_clk);
            budget--;
        end
        if (!o_valid) timeoutFail("bp_valid_wait");
        for (int k = 0; k < 20; k++) begin
            checkOutput("bp_valid", 320'(o_valid), 320'(1));
            checkOutput("bp_ready", 320'(o_ready), 320'(0));
            if (k == 10) begin
                i_valid  = 1'b1;
                i_state  = ~init_st;
                i_rounds = 4'd3;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge i_sys_clk);
        end
        i_valid     = 1'b0;
        ready_force = 1'b1;
        @(negedge i_sys_clk);
        @(negedge i_sys_clk);
        checkOutput("bp_release_ready", 320'(o_ready), 320'(1));
        checkOutput("bp_release_valid", 320'(o_valid), 320'(0));
        waitIdle();

        $display("[TB] reset during RUN");
        applyStimulus(init_st, 4'd12, 1'b0);
        repeat (4) @(posedge i_sys_clk);
        #2;
        i_sys_rst_n = 1'b0;
        #1;
        checkOutput("midrun_valid", 320'(o_valid), 320'(0));
        checkOutput("midrun_busy",  320'(o_busy),  320'(0));
        checkOutput("midrun_ready", 320'(o_ready), 320'(1));
        checkOutput("midrun_state", o_state, 320'(0));
        exp_q.delete();
        repeat (2) @(negedge i_sys_clk);
        i_sys_rst_n = 1'b1;
        applyStimulus(init_st, 4'd12, 1'b0);
        waitIdle();

        $display("[TB] random back-to-back with stalls");
        rand_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            for (int l = 0; l < 5; l++) rnd_st[l] = {$urandom(), $urandom()};
            r4 = 4'($urandom_range(1, 12));
            applyStimulus(rnd_st, r4, 1'b0);
        end
        rand_ready = 1'b0;
        waitIdle();
        checkOutput("queue_drained", 320'(exp_q.size()), 320'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
